sensor_conditioner: RTL and testbench
=====================================

Name: sensor_conditioner

Overview:
- Upstream stage of the traffic light controller FSM: cleans the raw farm-road vehicle detector and drives the controller's `sensor` input.
- Chain: 2-flop synchroniser, then debounce filter, then latched-call request FSM.
- The request FSM holds a vehicle call until the controller reports farm green, so a vehicle that pulls away early still gets served.
- Optional stuck-sensor detection suppresses a permanently asserted detector.

Parameters:
- DEBOUNCE_CYCLES, 4: consecutive synchronised cycles a new level must persist before acceptance; legal range 1..2**CNT_W-1.
- CNT_W, 8: width of the debounce counter.
- FARM_GREEN_CODE, 2'b00: `farm_light` encoding that means farm road green.
- STUCK_CYCLES, 1000: cycles of continuous debounced presence that declare a stuck sensor. Used only with the optional feature.

Ports:
- clk, input, 1: system clock, rising edge.
- rst_n, input, 1: asynchronous active-low reset.
- sensor_raw, input, 1: raw detector output; asynchronous to clk, may bounce.
- farm_light, input, 2: farm light code fed back from the controller.
- sensor, output, 1: conditioned vehicle call to the controller.
- sensor_stable, output, 1: debounced presence level.
- request_pending, output, 1: high while the FSM is in REQUEST.
- stuck_fault, output, 1: stuck-sensor flag; constant 0 when the feature is compiled out.

Behaviour:
- Reset:
  - rst_n low clears, immediately and asynchronously: sync stages, debounce counter, sensor_stable, FSM (to IDLE), stuck counter and all outputs.
  - All outputs are 0 during reset, independent of sensor_raw.
- Synchroniser: sync1 <= sensor_raw; sync2 <= sync1. Nothing else samples sensor_raw.
- Debounce:
  - On each edge where sync2 != sensor_stable: if cnt == DEBOUNCE_CYCLES-1, then sensor_stable <= sync2 and cnt <= 0; otherwise cnt <= cnt+1.
  - On any edge where sync2 == sensor_stable: cnt <= 0.
  - Latency: raw level stable from before edge N gives sensor_stable change at edge N+1+DEBOUNCE_CYCLES.
  - A pulse shorter than DEBOUNCE_CYCLES synchronised cycles is rejected.
- Request FSM (states IDLE, REQUEST, SERVE; next state evaluated from registered sensor_stable):
  - IDLE: sensor_stable=1 -> REQUEST.
  - REQUEST: farm_light==FARM_GREEN_CODE -> SERVE. Otherwise hold, even if sensor_stable falls (latched call).
  - SERVE: farm_light!=FARM_GREEN_CODE -> REQUEST if sensor_stable=1, else IDLE. Otherwise hold.
  - Simultaneous case: sensor_stable rises while farm is already green -> REQUEST, then SERVE one edge later.
- Output decode, from registers only (no combinational path from sensor_raw or farm_light):
  - sensor = (state==REQUEST) | (state==SERVE & sensor_stable).
  - request_pending = (state==REQUEST).
- Illegal/unused state encodings recover to IDLE on the next edge.

Optional Feature:
- Macro: SENSOR_STUCK_DETECT_EN.
- Defined:
  - A saturating counter increments every edge sensor_stable=1 and clears on any edge sensor_stable=0.
  - stuck_fault=1 when the counter == STUCK_CYCLES.
  - While stuck_fault=1: FSM forced to IDLE, sensor=0, request_pending=0.
  - The fault clears on the edge after sensor_stable falls.
- Undefined: no stuck counter is built, and stuck_fault is tied 0.

Test Plan (DEBOUNCE_CYCLES=4, 20 ns clock; farm_light red = 2'b10, yellow = 2'b01):
1. Reset and acceptance:
   - Stimulus: sensor_raw=1 throughout; rst_n low 2 cycles, then high at edge 0.
   - Required: all outputs 0 during reset; sensor_stable=1 at edge 5; sensor=1 and request_pending=1 at edge 6.
2. Glitch rejection:
   - Stimulus: sensor_raw high 3 cycles, then low; farm_light=2'b10.
   - Required: sensor_stable and sensor stay 0 throughout.
3. Latched call:
   - Stimulus: sensor_raw high 10 cycles, then low; farm_light held 2'b10 for 30 cycles, then 2'b00.
   - Required: sensor stays 1 after sensor_stable falls; sensor drops 1 edge after farm_light=2'b00; returns to IDLE when farm_light=2'b01.
4. Live presence during serve:
   - Stimulus: sensor_raw held high; farm_light=2'b00; then sensor_raw low.
   - Required: sensor stays 1 while sensor_raw is high; sensor falls 5 edges after sensor_raw falls.
   - Follow-up: farm_light=2'b01 with sensor_raw high -> back to REQUEST, sensor=1.
5. Reset mid-operation:
   - Stimulus: rst_n pulsed low between edges while in REQUEST.
   - Required: sensor, request_pending and sensor_stable go to 0 before the next edge.
6. Stuck sensor (SENSOR_STUCK_DETECT_EN, STUCK_CYCLES=16):
   - Stimulus: sensor_raw high 30 cycles; farm_light=2'b10; then sensor_raw low.
   - Required: stuck_fault=1 at edge 16 after sensor_stable rises, with sensor=0; fault clears 1 edge after sensor_stable falls.

Source files
------------

// File: rtl/sensor_conditioner.sv
// -----------------------------------------------------------------------------
// sensor_conditioner
//
// Purpose:
//   Cleans the raw farm-road vehicle detector before it reaches the traffic
//   light controller. The chain is a 2-flop synchroniser, a debounce filter
//   and a latched-call request FSM. The FSM holds a vehicle call until the
//   controller reports farm green, so a vehicle that pulls away early is
//   still served.
//
// Optional feature (compile-time macro SENSOR_STUCK_DETECT_EN):
//   When defined, a saturating presence counter flags a detector that has
//   been continuously asserted for STUCK_CYCLES cycles. While flagged, the
//   call is suppressed and the FSM is held in IDLE. When undefined, no
//   counter is built and stuck_fault is tied low.
//
// Ports:
//   clk             in   system clock, rising edge
//   rst_n           in   asynchronous active-low reset
//   sensor_raw      in   raw detector output, asynchronous to clk, may bounce
//   farm_light[1:0] in   farm light code fed back from the controller
//   sensor          out  conditioned vehicle call to the controller
//   sensor_stable   out  debounced presence level
//   request_pending out  high while the FSM is in REQUEST
//   stuck_fault     out  stuck-sensor flag (0 when the feature is compiled out)
// -----------------------------------------------------------------------------
module sensor_conditioner #(
    parameter int         DEBOUNCE_CYCLES = 4,
    parameter int         CNT_W           = 8,
    parameter logic [1:0] FARM_GREEN_CODE = 2'b00,
    parameter int         STUCK_CYCLES    = 1000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sensor_raw,
    input  logic [1:0] farm_light,
    output logic       sensor,
    output logic       sensor_stable,
    output logic       request_pending,
    output logic       stuck_fault
);

    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_REQUEST = 2'b01,
        ST_SERVE   = 2'b10
    } state_t;

    logic             sync1_q, sync2_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             stable_q, stable_d;
    state_t           state_q, state_d;
    logic             fault_w;
    logic             farm_green;

    // Synchroniser: the only place sensor_raw is sampled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= sensor_raw;
            sync2_q <= sync1_q;
        end
    end

    // Debounce: a new level must differ from the accepted level on
    // DEBOUNCE_CYCLES consecutive edges; any agreeing edge restarts the count.
    always_comb begin
        cnt_d    = '0;
        stable_d = stable_q;
        if (sync2_q != stable_q) begin
            if (cnt_q == DB_LAST) begin
                stable_d = sync2_q;
                cnt_d    = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            stable_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            stable_q <= stable_d;
        end
    end

`ifdef SENSOR_STUCK_DETECT_EN
    localparam int                 STUCK_W   = $clog2(STUCK_CYCLES + 1);
    localparam logic [STUCK_W-1:0] STUCK_MAX = STUCK_W'(STUCK_CYCLES);

    logic [STUCK_W-1:0] stuck_cnt_q, stuck_cnt_d;

    // Saturates at STUCK_MAX so the fault stays asserted until presence drops.
    always_comb begin
        stuck_cnt_d = stuck_cnt_q;
        if (!stable_q) begin
            stuck_cnt_d = '0;
        end else if (stuck_cnt_q != STUCK_MAX) begin
            stuck_cnt_d = stuck_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stuck_cnt_q <= '0;
        end else begin
            stuck_cnt_q <= stuck_cnt_d;
        end
    end

    assign fault_w = (stuck_cnt_q == STUCK_MAX);
`else
    // Keeps the threshold parameter referenced when the detector is absent.
    logic unused_stuck_cfg;
    assign unused_stuck_cfg = (STUCK_CYCLES > 0);

    assign fault_w = 1'b0;
`endif

    assign farm_green = (farm_light == FARM_GREEN_CODE);

    // Request FSM. REQUEST ignores sensor_stable so a departed vehicle's call
    // is still served; SERVE re-arms REQUEST if presence remains at end of green.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (stable_q) begin
                    state_d = ST_REQUEST;
                end
            end
            ST_REQUEST: begin
                if (farm_green) begin
                    state_d = ST_SERVE;
                end
            end
            ST_SERVE: begin
                if (!farm_green) begin
                    state_d = stable_q ? ST_REQUEST : ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        if (fault_w) begin
            state_d = ST_IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Outputs decode registered state only. The fault gate is needed because
    // the FSM reaches IDLE one edge after the fault is raised.
    assign request_pending = (state_q == ST_REQUEST) & ~fault_w;
    assign sensor          = ((state_q == ST_REQUEST) |
                              ((state_q == ST_SERVE) & stable_q)) & ~fault_w;
    assign sensor_stable   = stable_q;
    assign stuck_fault     = fault_w;

endmodule

// File: tb/tb_sensor_conditioner.sv
module tb_sensor_conditioner;

    logic       clk;
    logic       rst_n;
    logic       sensor_raw;
    logic [1:0] farm_light;
    logic       sensor;
    logic       sensor_stable;
    logic       request_pending;
    logic       stuck_fault;

    int n_vec  = 0;
    int n_miss = 0;

    sensor_conditioner #(
        .DEBOUNCE_CYCLES(4),
        .CNT_W          (8),
        .FARM_GREEN_CODE(2'b00),
        .STUCK_CYCLES   (16)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .sensor_raw     (sensor_raw),
        .farm_light     (farm_light),
        .sensor         (sensor),
        .sensor_stable  (sensor_stable),
        .request_pending(request_pending),
        .stuck_fault    (stuck_fault)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    // Each record: inputs held for n edges, outputs expected after every one.
    typedef struct {
        string      name;
        logic       raw;
        logic [1:0] farm;
        int         n;
        logic       e_stable;
        logic       e_sensor;
        logic       e_req;
        logic       e_fault;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input string nm, input logic r, input logic [1:0] f,
                                input int n, input logic s, input logic sn,
                                input logic rq, input logic ft);
        vec_t v;
        v.name = nm; v.raw = r; v.farm = f; v.n = n;
        v.e_stable = s; v.e_sensor = sn; v.e_req = rq; v.e_fault = ft;
        vecs.push_back(v);
    endfunction

    task automatic check(input string nm, input logic s, input logic sn,
                         input logic rq, input logic ft);
        logic [3:0] act, exp;
        act = {sensor_stable, sensor, request_pending, stuck_fault};
        exp = {s, sn, rq, ft};
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s t=%0t {stable,sensor,req,fault} got %b expected %b",
                     nm, $time, act, exp);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    initial begin
        // ---------------- vector table ----------------
        // Glitch rejection: 3 synchronised cycles high is one short of 4.
        add("glitch_hi",      1'b1, 2'b10, 3,  0, 0, 0, 0);
        add("glitch_lo",      1'b0, 2'b10, 8,  0, 0, 0, 0);
        // Latched call: accepted on the 6th edge, REQUEST on the 7th.
        add("latch_wait",     1'b1, 2'b10, 5,  0, 0, 0, 0);
        add("latch_stable",   1'b1, 2'b10, 1,  1, 0, 0, 0);
        add("latch_req",      1'b1, 2'b10, 4,  1, 1, 1, 0);
        add("latch_fallwait", 1'b0, 2'b10, 5,  1, 1, 1, 0);
        add("latch_fall",     1'b0, 2'b10, 1,  0, 1, 1, 0);
        add("latch_hold",     1'b0, 2'b10, 15, 0, 1, 1, 0);
        add("latch_serve",    1'b0, 2'b00, 3,  0, 0, 0, 0);
        add("latch_idle",     1'b0, 2'b01, 2,  0, 0, 0, 0);
        add("latch_idle_red", 1'b0, 2'b10, 2,  0, 0, 0, 0);
        // Live presence with farm already green: REQUEST then SERVE.
        add("live_wait",      1'b1, 2'b00, 5,  0, 0, 0, 0);
        add("live_stable",    1'b1, 2'b00, 1,  1, 0, 0, 0);
        add("live_req",       1'b1, 2'b00, 1,  1, 1, 1, 0);
        add("live_serve",     1'b1, 2'b00, 6,  1, 1, 0, 0);
        add("live_fallwait",  1'b0, 2'b00, 5,  1, 1, 0, 0);
        add("live_fall",      1'b0, 2'b00, 3,  0, 0, 0, 0);
        add("serve_rewait",   1'b1, 2'b00, 5,  0, 0, 0, 0);
        add("serve_rearm",    1'b1, 2'b00, 1,  1, 1, 0, 0);
        add("serve_live",     1'b1, 2'b00, 2,  1, 1, 0, 0);
        add("yellow_rereq",   1'b1, 2'b01, 4,  1, 1, 1, 0);
        add("green_again",    1'b1, 2'b00, 1,  1, 1, 0, 0);
        add("red_rereq",      1'b0, 2'b10, 5,  1, 1, 1, 0);
        add("red_latched",    1'b0, 2'b10, 3,  0, 1, 1, 0);
        add("drain_serve",    1'b0, 2'b00, 1,  0, 0, 0, 0);
        add("drain_idle",     1'b0, 2'b01, 1,  0, 0, 0, 0);
        add("drain_red",      1'b0, 2'b10, 1,  0, 0, 0, 0);
        // Long presence: stuck detection (STUCK_CYCLES=16) when compiled in.
        add("long_wait",      1'b1, 2'b10, 5,  0, 0, 0, 0);
        add("long_stable",    1'b1, 2'b10, 1,  1, 0, 0, 0);
        add("long_req",       1'b1, 2'b10, 4,  1, 1, 1, 0);
`ifdef SENSOR_STUCK_DETECT_EN
        add("stuck_pre",      1'b1, 2'b10, 11, 1, 1, 1, 0);
        add("stuck_set",      1'b1, 2'b10, 1,  1, 0, 0, 1);
        add("stuck_hold",     1'b1, 2'b10, 8,  1, 0, 0, 1);
        add("stuck_fallwait", 1'b0, 2'b10, 5,  1, 0, 0, 1);
        add("stuck_fall",     1'b0, 2'b10, 1,  0, 0, 0, 1);
        add("stuck_clear",    1'b0, 2'b10, 3,  0, 0, 0, 0);
`else
        add("nostuck_hold",   1'b1, 2'b10, 20, 1, 1, 1, 0);
        add("nostuck_fwait",  1'b0, 2'b10, 5,  1, 1, 1, 0);
        add("nostuck_fall",   1'b0, 2'b10, 4,  0, 1, 1, 0);
`endif

        // ---------------- reset and acceptance ----------------
        rst_n      = 1'b0;
        sensor_raw = 1'b1;
        farm_light = 2'b10;
        repeat (2) begin
            @(posedge clk); #1;
            check("reset_hold", 0, 0, 0, 0);
        end
        #2 rst_n = 1'b1;
        for (int e = 0; e <= 6; e++) begin
            @(posedge clk); #1;
            check($sformatf("accept_e%0d", e), (e >= 5), (e >= 6), (e >= 6), 0);
        end

        // ---------------- asynchronous reset while in REQUEST ----------------
        rst_n = 1'b0;
        #2;
        check("reset_async", 0, 0, 0, 0);
        sensor_raw = 1'b0;
        #2 rst_n = 1'b1;

        // ---------------- table-driven sequences ----------------
        for (int i = 0; i < vecs.size(); i++) begin
            sensor_raw = vecs[i].raw;
            farm_light = vecs[i].farm;
            for (int k = 0; k < vecs[i].n; k++) begin
                @(posedge clk); #1;
                check(vecs[i].name, vecs[i].e_stable, vecs[i].e_sensor,
                      vecs[i].e_req, vecs[i].e_fault);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
